// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared FSM encoding and counter sizing helper for the tick generator
package tick_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        HOLD   = 2'd2,
        REPEAT = 2'd3
    } btn_state_t;

    function automatic int cw(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_cond.sv
// btn_cond: synchronises, debounces and auto-repeats the set button into one-cycle INC pulses
module btn_cond
    import tick_gen_pkg::*;
#(
    parameter int DEB     = 1_000_000,
    parameter int REP_DLY = 25_000_000,
    parameter int REP_PER = 10_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic INC
);

    localparam int DW = cw(DEB + 1);
    localparam int RW = cw(REP_DLY > REP_PER ? REP_DLY : REP_PER);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_DLY - 2);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PER - 1);

    logic          s1, s, deb;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt, rcnt_n;
    logic          inc_n;
    btn_state_t    state, state_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1   <= 1'b0;
            s    <= 1'b0;
            deb  <= 1'b0;
            dcnt <= '0;
        end else begin
            s1 <= BTN;
            s  <= s1;
            if (s == deb) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                deb  <= s;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            rcnt  <= '0;
            INC   <= 1'b0;
        end else begin
            state <= state_n;
            rcnt  <= rcnt_n;
            INC   <= inc_n;
        end
    end

    // HOLD fires one count early because PRESS already consumed one clock of the delay
    always_comb begin
        state_n = state;
        rcnt_n  = rcnt + 1'b1;
        inc_n   = 1'b0;
        case (state)
            IDLE: begin
                rcnt_n = '0;
                if (deb) begin
                    state_n = PRESS;
                    inc_n   = 1'b1;
                end
            end
            PRESS: begin
                rcnt_n  = '0;
                state_n = deb ? HOLD : IDLE;
            end
            HOLD: begin
                if (!deb) begin
                    state_n = IDLE;
                end else if (rcnt == DLY_LAST) begin
                    state_n = REPEAT;
                    inc_n   = 1'b1;
                    rcnt_n  = '0;
                end
            end
            REPEAT: begin
                if (!deb) begin
                    state_n = IDLE;
                end else if (rcnt == PER_LAST) begin
                    inc_n  = 1'b1;
                    rcnt_n = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/tick_gen.sv
// tick_gen: clock prescaler producing EN tick and BLINK square wave, plus conditioned button INC
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int DIV     = 50_000_000,
    parameter int DEB     = 1_000_000,
    parameter int REP_DLY = 25_000_000,
    parameter int REP_PER = 10_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic EN,
    output logic INC,
    output logic BLINK
);

    localparam int CW = cw(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            EN    <= 1'b0;
            BLINK <= 1'b0;
        end else begin
            cnt   <= cnt == LAST ? '0 : cnt + 1'b1;
            EN    <= cnt == LAST;
            BLINK <= BLINK ^ (cnt == LAST || cnt == HALF);
        end
    end

    btn_cond #(
        .DEB    (DEB),
        .REP_DLY(REP_DLY),
        .REP_PER(REP_PER)
    ) u_btn (
        .CLK(CLK),
        .RST(RST),
        .BTN(BTN),
        .INC(INC)
    );

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: scoreboard bench; stimulus queues expected pulse cycles, a negedge monitor matches them
module tb_tick_gen;

    localparam int DIV = 10, DEB = 4, REP_DLY = 20, REP_PER = 5;

    logic CLK = 1'b0, RST = 1'b1, BTN = 1'b0;
    logic EN, INC, BLINK;
    logic prev_blink = 1'b0;
    int   cyc = 0, base = 0, tests = 0, fails = 0;
    bit   mon_on = 1'b0;
    int   q[3][$];
    int   rst_q[$];

    tick_gen #(.DIV(DIV), .DEB(DEB), .REP_DLY(REP_DLY), .REP_PER(REP_PER)) dut (
        .CLK(CLK), .RST(RST), .BTN(BTN), .EN(EN), .INC(INC), .BLINK(BLINK)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // q[0]=EN pulses, q[1]=INC pulses, q[2]=BLINK toggles, each as the cycle count after the edge
    always @(negedge CLK) begin
        if (mon_on) begin
            if (rst_q.size() > 0 && rst_q[0] == cyc) begin
                void'(rst_q.pop_front());
                tests++;
                if ({EN, INC, BLINK} !== 3'b000) begin
                    fails++;
                    $display("FAIL reset@%0d: en/inc/blink=%b%b%b, want 000", cyc, EN, INC, BLINK);
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    bit obs, hit;
                    obs = k == 0 ? EN === 1'b1 : k == 1 ? INC === 1'b1 : BLINK !== prev_blink;
                    while (q[k].size() > 0 && q[k][0] < cyc) begin
                        tests++;
                        fails++;
                        $display("FAIL %s@%0d: no event seen, want event", k == 0 ? "en" : k == 1 ? "inc" : "blink", q[k][0]);
                        void'(q[k].pop_front());
                    end
                    hit = q[k].size() > 0 && q[k][0] == cyc;
                    if (obs || hit) begin
                        tests++;
                        if (obs != hit) begin
                            fails++;
                            $display("FAIL %s@%0d: event=%0b, want %0b", k == 0 ? "en" : k == 1 ? "inc" : "blink", cyc, obs, hit);
                        end
                        if (hit) void'(q[k].pop_front());
                    end
                end
            end
            prev_blink = BLINK;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            int j;
            j = cyc + 1 - base;
            if (j > 0 && j % DIV == 0) q[0].push_back(cyc + 1);
            if (j > 0 && j % (DIV / 2) == 0) q[2].push_back(cyc + 1);
            @(negedge CLK);
        end
    endtask

    task automatic do_rst(input int n);
        RST = 1'b1;
        repeat (n) begin
            rst_q.push_back(cyc + 1);
            @(negedge CLK);
        end
        RST  = 1'b0;
        base = cyc;
    endtask

    initial begin
        int n;
        @(negedge CLK);
        mon_on = 1'b1;
        do_rst(3);
        tick(40);
        BTN = 1'b1;
        tick(3);
        BTN = 1'b0;
        tick(15);
        BTN = 1'b1;
        n = cyc + 1;
        q[1].push_back(n + 6);
        tick(15);
        BTN = 1'b0;
        tick(20);
        BTN = 1'b1;
        n = cyc + 1;
        q[1].push_back(n + 6);
        for (int k = 0; k < 8; k++) q[1].push_back(n + 26 + k * REP_PER);
        tick(60);
        BTN = 1'b0;
        tick(20);
        BTN = 1'b1;
        n = cyc + 1;
        q[1].push_back(n + 6);
        q[1].push_back(n + 26);
        q[1].push_back(n + 31);
        tick(33);
        do_rst(2);
        q[1].push_back(base + 7);
        tick(10);
        BTN = 1'b0;
        tick(20);
        while ((cyc + 7 - base) % DIV != 0) tick(1);
        BTN = 1'b1;
        q[1].push_back(cyc + 7);
        tick(12);
        BTN = 1'b0;
        tick(20);
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            while (q[k].size() > 0) begin
                tests++;
                fails++;
                $display("FAIL %s@%0d: no event seen, want event", k == 0 ? "en" : k == 1 ? "inc" : "blink", q[k][0]);
                void'(q[k].pop_front());
            end
        end
        while (rst_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL reset@%0d: not checked, want 000", rst_q[0]);
            void'(rst_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
